// File: rtl/seq_alu.sv
// seq_alu: multi-cycle EX-stage ALU with one-cycle logic/arith ops and a shift-add multiply
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   start       request; ALU_ctrl/in0/in1 sampled on the accepting edge
//   ALU_ctrl    000 add, 001 sub, 010 and, 011 or, 100 slt, 101 mul, 110 xor, 111 nor
//   in0, in1    operands A and B
//   busy        multiply in progress; start is ignored while high
//   done        one-cycle pulse when ALU_output/zero have just been updated
//   zero        ALU_output == 0, registered with the result
//   ALU_output  result, held until the next done
//   overflow    present only when SEQ_ALU_OVF_EN is defined
//
// Optional feature macro: SEQ_ALU_OVF_EN adds the overflow output and widens the
// multiply accumulator to 2*inst_SIZE so the full product is visible.
module seq_alu #(
    parameter  int inst_SIZE = 16,
    localparam int CNT_W     = $clog2(inst_SIZE) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2:0]           ALU_ctrl,
    input  logic [inst_SIZE-1:0] in0,
    input  logic [inst_SIZE-1:0] in1,
    output logic                 busy,
    output logic                 done,
    output logic                 zero,
    output logic [inst_SIZE-1:0] ALU_output
`ifdef SEQ_ALU_OVF_EN
    ,
    output logic                 overflow
`endif
);

    localparam int W = inst_SIZE;
`ifdef SEQ_ALU_OVF_EN
    localparam int AW = 2 * W;
`else
    localparam int AW = W;
`endif

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           r_state, w_state_nxt;
    logic [AW-1:0]    r_acc, r_mcand, w_acc_nxt;
    logic [W-1:0]     r_mplier, r_out, w_res, w_add, w_sub;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done, r_zero, w_mul_req, w_last, w_busy;

    assign w_mul_req = start && (ALU_ctrl == 3'b101);
    assign w_last    = (r_cnt == CNT_W'(inst_SIZE - 1));
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_add     = in0 + in1;
    assign w_sub     = in0 - in1;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_IDLE)
            w_state_nxt = w_mul_req ? S_MUL : S_IDLE;
        else
            w_state_nxt = w_last ? S_IDLE : S_MUL;
    end

    // FSM outputs
    always_comb begin
        w_busy = (r_state == S_MUL);
    end

    // Single-cycle result
    always_comb begin
        w_res = '0;
        case (ALU_ctrl)
            3'b000:  w_res = w_add;
            3'b001:  w_res = w_sub;
            3'b010:  w_res = in0 & in1;
            3'b011:  w_res = in0 | in1;
            3'b100:  w_res = W'($signed(in0) < $signed(in1));
            3'b110:  w_res = in0 ^ in1;
            3'b111:  w_res = ~(in0 | in1);
            default: w_res = '0;
        endcase
    end

`ifdef SEQ_ALU_OVF_EN
    logic r_ovf, w_res_ovf;
    // Signed overflow: operands agree in sign (add) or differ (sub) and the result sign flips
    always_comb begin
        w_res_ovf = 1'b0;
        if (ALU_ctrl == 3'b000)
            w_res_ovf = (in0[W-1] == in1[W-1]) && (w_add[W-1] != in0[W-1]);
        else if (ALU_ctrl == 3'b001)
            w_res_ovf = (in0[W-1] != in1[W-1]) && (w_sub[W-1] != in0[W-1]);
    end
    assign overflow = r_ovf;
`endif

    // Datapath: result register and shift-add multiplier
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_out    <= '0;
            r_zero   <= 1'b0;
            r_done   <= 1'b0;
`ifdef SEQ_ALU_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_mul_req) begin
                    r_mcand  <= AW'(in0);
                    r_mplier <= in1;
                    r_acc    <= '0;
                    r_cnt    <= '0;
                end else if (start) begin
                    r_out  <= w_res;
                    r_zero <= (w_res == '0);
                    r_done <= 1'b1;
`ifdef SEQ_ALU_OVF_EN
                    r_ovf  <= w_res_ovf;
`endif
                end
            end else begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CNT_W'(1);
                // The last iteration's sum goes straight to the result register
                if (w_last) begin
                    r_out  <= w_acc_nxt[W-1:0];
                    r_zero <= (w_acc_nxt[W-1:0] == '0);
                    r_done <= 1'b1;
`ifdef SEQ_ALU_OVF_EN
                    r_ovf  <= |w_acc_nxt[AW-1:W];
`endif
                end
            end
        end
    end

    assign busy       = w_busy;
    assign done       = r_done;
    assign zero       = r_zero;
    assign ALU_output = r_out;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu with inst_SIZE=16
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  ALU_ctrl = 3'b000;
    logic [15:0] in0 = '0;
    logic [15:0] in1 = '0;
    logic        busy, done, zero;
    logic [15:0] ALU_output;
`ifdef SEQ_ALU_OVF_EN
    logic        overflow;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    seq_alu #(.inst_SIZE(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .ALU_ctrl(ALU_ctrl),
        .in0(in0),
        .in1(in1),
        .busy(busy),
        .done(done),
        .zero(zero),
        .ALU_output(ALU_output)
`ifdef SEQ_ALU_OVF_EN
        ,
        .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single accepting edge, then drop start
    task automatic issue(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
        start = 1'b1;
        ALU_ctrl = c;
        in0 = a;
        in1 = b;
        tick();
        start = 1'b0;
    endtask

    // Bounded wait for done; reports whether it arrived
    task automatic wait_done(output bit seen);
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (done === 1'b1) seen = 1;
            else tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else pass_cnt++;
        total_cnt++; if (zero !== 1'b0) $display("FAIL reset_zero got=%b exp=0", zero); else pass_cnt++;
        total_cnt++; if (ALU_output !== 16'h0000) $display("FAIL reset_out got=%h exp=0000", ALU_output); else pass_cnt++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        issue(3'b000, 16'h1234, 16'h0FFF);
        total_cnt++; if (done !== 1'b1) $display("FAIL add_done got=%b exp=1", done); else pass_cnt++;
        total_cnt++; if (ALU_output !== 16'h2233) $display("FAIL add_out got=%h exp=2233", ALU_output); else pass_cnt++;
        total_cnt++; if (zero !== 1'b0) $display("FAIL add_zero got=%b exp=0", zero); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL add_busy got=%b exp=0", busy); else pass_cnt++;
        tick();
        total_cnt++; if (done !== 1'b0) $display("FAIL add_done_pulse got=%b exp=0", done); else pass_cnt++;
        total_cnt++; if (ALU_output !== 16'h2233) $display("FAIL add_hold got=%h exp=2233", ALU_output); else pass_cnt++;
    endtask

    task automatic test_sub_slt_logic();
        issue(3'b001, 16'h00A5, 16'h00A5);
        total_cnt++; if (ALU_output !== 16'h0000) $display("FAIL sub_out got=%h exp=0000", ALU_output); else pass_cnt++;
        total_cnt++; if (zero !== 1'b1) $display("FAIL sub_zero got=%b exp=1", zero); else pass_cnt++;
        issue(3'b100, 16'hFFFF, 16'h0001);
        total_cnt++; if (ALU_output !== 16'h0001) $display("FAIL slt_neg_out got=%h exp=0001", ALU_output); else pass_cnt++;
        total_cnt++; if (zero !== 1'b0) $display("FAIL slt_neg_zero got=%b exp=0", zero); else pass_cnt++;
        issue(3'b100, 16'h0001, 16'hFFFF);
        total_cnt++; if (ALU_output !== 16'h0000) $display("FAIL slt_pos_out got=%h exp=0000", ALU_output); else pass_cnt++;
        issue(3'b010, 16'hF0F0, 16'h0FF0);
        total_cnt++; if (ALU_output !== 16'h00F0) $display("FAIL and_out got=%h exp=00F0", ALU_output); else pass_cnt++;
        issue(3'b011, 16'hF0F0, 16'h0FF0);
        total_cnt++; if (ALU_output !== 16'hFFF0) $display("FAIL or_out got=%h exp=FFF0", ALU_output); else pass_cnt++;
        issue(3'b001, 16'h0000, 16'h0001);
        total_cnt++; if (ALU_output !== 16'hFFFF) $display("FAIL sub_wrap got=%h exp=FFFF", ALU_output); else pass_cnt++;
    endtask

    task automatic test_mul();
        int busy_n = 0;
        int done_n = 0;
        int done_at = 0;
        issue(3'b101, 16'h0012, 16'h0034);
        for (int n = 1; n <= 25; n++) begin
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) begin
                done_n++;
                if (done_at == 0) done_at = n;
            end
            // Inject a competing add while busy, with new operands
            start = (n == 5);
            ALU_ctrl = (n == 5) ? 3'b000 : 3'b101;
            in0 = 16'h1111;
            in1 = 16'h2222;
            tick();
        end
        start = 1'b0;
        total_cnt++; if (busy_n != 16) $display("FAIL mul_busy_cycles got=%0d exp=16", busy_n); else pass_cnt++;
        total_cnt++; if (done_at != 17) $display("FAIL mul_latency got=%0d exp=17", done_at); else pass_cnt++;
        total_cnt++; if (done_n != 1) $display("FAIL mul_done_count got=%0d exp=1", done_n); else pass_cnt++;
        total_cnt++; if (ALU_output !== 16'h03A8) $display("FAIL mul_out got=%h exp=03A8", ALU_output); else pass_cnt++;
        total_cnt++; if (zero !== 1'b0) $display("FAIL mul_zero got=%b exp=0", zero); else pass_cnt++;
    endtask

    task automatic test_mul_ovf();
        bit seen;
        issue(3'b101, 16'h0100, 16'h0100);
        wait_done(seen);
        total_cnt++; if (!seen) $display("FAIL mul2_timeout got=no_done exp=done"); else pass_cnt++;
        total_cnt++; if (ALU_output !== 16'h0000) $display("FAIL mul2_out got=%h exp=0000", ALU_output); else pass_cnt++;
        total_cnt++; if (zero !== 1'b1) $display("FAIL mul2_zero got=%b exp=1", zero); else pass_cnt++;
`ifdef SEQ_ALU_OVF_EN
        total_cnt++; if (overflow !== 1'b1) $display("FAIL mul2_ovf got=%b exp=1", overflow); else pass_cnt++;
`endif
        tick();
        issue(3'b000, 16'h7FFF, 16'h0001);
        total_cnt++; if (ALU_output !== 16'h8000) $display("FAIL add_ovf_out got=%h exp=8000", ALU_output); else pass_cnt++;
`ifdef SEQ_ALU_OVF_EN
        total_cnt++; if (overflow !== 1'b1) $display("FAIL add_ovf got=%b exp=1", overflow); else pass_cnt++;
        issue(3'b010, 16'hFFFF, 16'hFFFF);
        total_cnt++; if (overflow !== 1'b0) $display("FAIL and_ovf got=%b exp=0", overflow); else pass_cnt++;
`endif
    endtask

    task automatic test_reset_mid_mul();
        int done_n = 0;
        issue(3'b101, 16'h0005, 16'h0007);
        for (int n = 1; n < 5; n++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_mul_busy got=%b exp=0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL rst_mul_done got=%b exp=0", done); else pass_cnt++;
        total_cnt++; if (ALU_output !== 16'h0000) $display("FAIL rst_mul_out got=%h exp=0000", ALU_output); else pass_cnt++;
        total_cnt++; if (zero !== 1'b0) $display("FAIL rst_mul_zero got=%b exp=0", zero); else pass_cnt++;
        for (int n = 0; n < 20; n++) begin
            if (done === 1'b1) done_n++;
            tick();
        end
        total_cnt++; if (done_n != 0) $display("FAIL rst_mul_stray_done got=%0d exp=0", done_n); else pass_cnt++;
        issue(3'b000, 16'h0003, 16'h0004);
        total_cnt++; if (done !== 1'b1) $display("FAIL post_rst_done got=%b exp=1", done); else pass_cnt++;
        total_cnt++; if (ALU_output !== 16'h0007) $display("FAIL post_rst_out got=%h exp=0007", ALU_output); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        tick();
        start = 1'b1;
        ALU_ctrl = 3'b110;
        in0 = 16'hF0F0;
        in1 = 16'hFFFF;
        tick();
        total_cnt++; if (done !== 1'b1) $display("FAIL b2b_done1 got=%b exp=1", done); else pass_cnt++;
        total_cnt++; if (ALU_output !== 16'h0F0F) $display("FAIL b2b_out1 got=%h exp=0F0F", ALU_output); else pass_cnt++;
        ALU_ctrl = 3'b111;
        in0 = 16'h0000;
        in1 = 16'h0000;
        tick();
        start = 1'b0;
        total_cnt++; if (done !== 1'b1) $display("FAIL b2b_done2 got=%b exp=1", done); else pass_cnt++;
        total_cnt++; if (ALU_output !== 16'hFFFF) $display("FAIL b2b_out2 got=%h exp=FFFF", ALU_output); else pass_cnt++;
        tick();
        total_cnt++; if (done !== 1'b0) $display("FAIL b2b_done_end got=%b exp=0", done); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_slt_logic();
        test_mul();
        test_mul_ovf();
        test_reset_mid_mul();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
